// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: inst/data request-ack ports to a single-outstanding AXI master; CPU_AXI_BRIDGE_POSTED_WR_EN acks stores at AW/W acceptance
module cpu_axi_bridge #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
`ifdef CPU_AXI_BRIDGE_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t state;
  logic src_data, data_ok_r, gnt_data, gnt_inst, idle, wr_fire;
  logic [31:0] addr;
  assign idle = state == IDLE && !reset;
  assign gnt_data = data_req && (DATA_FIRST || !inst_req);
  assign gnt_inst = inst_req && !gnt_data;
  assign inst_addr_ok = idle && gnt_inst;
  assign data_addr_ok = idle && gnt_data;
  // AW and W each retire on their own handshake; leave once neither is still pending
  assign wr_fire = state == WR_REQ && (!awvalid || awready) && (!wvalid || wready);
  assign data_data_ok = data_ok_r || (POSTED && wr_fire);
  assign araddr = addr;
  assign awaddr = addr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      src_data <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      inst_data_ok <= 1'b0;
      data_ok_r <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_data_ok <= 1'b0;
      data_ok_r <= 1'b0;
      case (state)
        IDLE: if (inst_addr_ok || data_addr_ok) begin
          src_data <= gnt_data;
          addr <= gnt_data ? data_addr : inst_addr;
          if (gnt_data && data_wr) begin
            wdata <= data_wdata;
            wstrb <= data_wstrb;
            awvalid <= 1'b1;
            wvalid <= 1'b1;
            state <= WR_REQ;
          end else begin
            arvalid <= 1'b1;
            state <= RD_ADDR;
          end
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready <= 1'b1;
          state <= RD_DATA;
        end
        RD_DATA: if (rvalid) begin
          rready <= 1'b0;
          if (src_data) data_rdata <= rdata;
          else inst_rdata <= rdata;
          inst_data_ok <= !src_data;
          data_ok_r <= src_data;
          state <= DONE;
        end
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (wr_fire) begin
            bready <= 1'b1;
            state <= WR_RESP;
          end
        end
        // posted stores were already acked, so B only gates the return to IDLE
        WR_RESP: if (bvalid) begin
          bready <= 1'b0;
          data_ok_r <= !POSTED;
          state <= POSTED ? IDLE : DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed checks of cpu_axi_bridge; dut uses DATA_FIRST=1, dut0 shares inputs with DATA_FIRST=0
module tb_cpu_axi_bridge;
`ifdef CPU_AXI_BRIDGE_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic inst_req = 0, data_req = 0, data_wr = 0, arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, rdata = 0;
  logic [3:0] data_wstrb = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] inst_rdata, data_rdata, araddr, awaddr, wdata;
  logic [3:0] wstrb;
  logic b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
  logic [31:0] b_inst_rdata, b_data_rdata, b_araddr, b_awaddr, b_wdata;
  logic [3:0] b_wstrb;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bvalid(bvalid),
    .bready(bready));

  cpu_axi_bridge #(.DATA_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(b_inst_addr_ok),
    .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(b_data_addr_ok),
    .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata), .araddr(b_araddr), .arvalid(b_arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(b_rready), .awaddr(b_awaddr), .awvalid(b_awvalid),
    .awready(awready), .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(wready), .bvalid(bvalid),
    .bready(b_bready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    tick(); #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_inst_ok", inst_data_ok, 0);
    reset = 0;

    // single fetch, all ready
    tick(); inst_req = 1; inst_addr = 32'h1C000000; arready = 1; rvalid = 1; rdata = 32'h02800C0C; #1;
    chk("f_c0_inst_aok", inst_addr_ok, 1);
    chk("f_c0_data_aok", data_addr_ok, 0);
    tick(); inst_req = 0; #1;
    chk("f_c1_arvalid", arvalid, 1);
    chk("f_c1_araddr", araddr, 32'h1C000000);
    tick(); #1;
    chk("f_c2_rready", rready, 1);
    chk("f_c2_inst_dok", inst_data_ok, 0);
    tick(); #1;
    chk("f_c3_inst_dok", inst_data_ok, 1);
    chk("f_c3_inst_rdata", inst_rdata, 32'h02800C0C);
    tick(); arready = 0; rvalid = 0; #1;
    chk("f_c4_inst_dok", inst_data_ok, 0);

    // store with awready delayed, wready immediate
    tick(); data_req = 1; data_wr = 1; data_addr = 32'h00001004; data_wdata = 32'hAABBCCDD;
    data_wstrb = 4'b0011; wready = 1; #1;
    chk("s_c0_data_aok", data_addr_ok, 1);
    tick(); data_req = 0; data_wr = 0; #1;
    chk("s_c1_awvalid", awvalid, 1);
    chk("s_c1_wvalid", wvalid, 1);
    chk("s_c1_awaddr", awaddr, 32'h00001004);
    chk("s_c1_wdata", wdata, 32'hAABBCCDD);
    chk("s_c1_wstrb", wstrb, 4'b0011);
    tick(); #1;
    chk("s_c2_wvalid", wvalid, 0);
    chk("s_c2_awvalid", awvalid, 1);
    chk("s_c2_awaddr", awaddr, 32'h00001004);
    tick(); awready = 1; #1;
    chk("s_c3_awvalid", awvalid, 1);
    chk("s_c3_data_dok", data_data_ok, POSTED);
    tick(); awready = 0; wready = 0; #1;
    chk("s_c4_awvalid", awvalid, 0);
    chk("s_c4_bready", bready, 1);
    chk("s_c4_data_dok", data_data_ok, 0);
    tick(); bvalid = 1; #1;
    chk("s_c5_bready", bready, 1);
    tick(); bvalid = 0; #1;
    chk("s_c6_data_dok", data_data_ok, !POSTED);
    chk("s_c6_bready", bready, 0);
    tick(); #1;
    chk("s_c7_data_dok", data_data_ok, 0);

    // simultaneous inst + data load: DATA_FIRST=1 (dut) vs 0 (dut0)
    tick(); inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200;
    arready = 1; rvalid = 1; rdata = 32'h11111111; #1;
    chk("a_c0_df1_data_aok", data_addr_ok, 1);
    chk("a_c0_df1_inst_aok", inst_addr_ok, 0);
    chk("a_c0_df0_inst_aok", b_inst_addr_ok, 1);
    chk("a_c0_df0_data_aok", b_data_addr_ok, 0);
    tick(); data_req = 0; #1;
    chk("a_c1_df1_araddr", araddr, 32'h200);
    chk("a_c1_df0_araddr", b_araddr, 32'h100);
    chk("a_c1_inst_aok", inst_addr_ok, 0);
    tick(); #1;
    tick(); #1;
    chk("a_c3_df1_data_dok", data_data_ok, 1);
    chk("a_c3_df1_data_rdata", data_rdata, 32'h11111111);
    chk("a_c3_inst_aok", inst_addr_ok, 0);
    chk("a_c3_df0_inst_dok", b_inst_data_ok, 1);
    chk("a_c3_df0_data_dok", b_data_data_ok, 0);
    tick(); #1;
    chk("a_c4_df1_inst_aok", inst_addr_ok, 1);
    chk("a_c4_df1_data_aok", data_addr_ok, 0);
    tick(); inst_req = 0; rdata = 32'h22222222; #1;
    chk("a_c5_araddr", araddr, 32'h100);
    tick(); #1;
    tick(); #1;
    chk("a_c7_inst_dok", inst_data_ok, 1);
    chk("a_c7_inst_rdata", inst_rdata, 32'h22222222);
    chk("a_c7_data_rdata_hold", data_rdata, 32'h11111111);

    // back-to-back loads with arready low for 5 cycles
    tick(); data_req = 1; data_addr = 32'h300; arready = 0; rvalid = 1; rdata = 32'h33333333; #1;
    chk("b_c0_data_aok", data_addr_ok, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(); data_addr = 32'h304; #1;
      chk("b_stall_araddr", araddr, 32'h300);
      chk("b_stall_arvalid", arvalid, 1);
      chk("b_stall_aok", data_addr_ok, 0);
    end
    tick(); arready = 1; #1;
    chk("b_c5_araddr", araddr, 32'h300);
    tick(); #1;
    chk("b_c6_aok", data_addr_ok, 0);
    tick(); #1;
    chk("b_c7_data_dok", data_data_ok, 1);
    chk("b_c7_data_rdata", data_rdata, 32'h33333333);
    chk("b_c7_aok", data_addr_ok, 0);
    tick(); #1;
    chk("b_c8_aok", data_addr_ok, 1);
    tick(); data_req = 0; rdata = 32'h55555555; #1;
    chk("b_c9_araddr", araddr, 32'h304);
    tick(); #1;
    tick(); #1;
    chk("b_c11_data_rdata", data_rdata, 32'h55555555);
    tick(); #1;

    // asynchronous reset while in RD_DATA
    tick(); inst_req = 1; inst_addr = 32'h1C000004; arready = 1; rvalid = 0; #1;
    chk("r_c0_inst_aok", inst_addr_ok, 1);
    tick(); inst_req = 0; #1;
    tick(); #1;
    chk("r_c2_rready", rready, 1);
    #2 reset = 1; #1;
    chk("r_async_rready", rready, 0);
    chk("r_async_araddr", araddr, 0);
    chk("r_async_inst_rdata", inst_rdata, 0);
    chk("r_async_data_rdata", data_rdata, 0);
    tick(); reset = 0;
    tick(); inst_req = 1; rvalid = 1; rdata = 32'h44444444; #1;
    chk("r_n0_inst_aok", inst_addr_ok, 1);
    tick(); inst_req = 0; #1;
    chk("r_n1_araddr", araddr, 32'h1C000004);
    tick(); #1;
    tick(); #1;
    chk("r_n3_inst_dok", inst_data_ok, 1);
    chk("r_n3_inst_rdata", inst_rdata, 32'h44444444);
    tick(); arready = 0; rvalid = 0; #1;

`ifdef CPU_AXI_BRIDGE_POSTED_WR_EN
    // posted store: ack at AW/W acceptance, hold off new grants until B
    tick(); data_req = 1; data_wr = 1; data_addr = 32'h2000; data_wdata = 32'h12345678; data_wstrb = 4'hF;
    awready = 1; wready = 1; #1;
    chk("p_c0_data_aok", data_addr_ok, 1);
    tick(); data_req = 0; data_wr = 0; inst_req = 1; inst_addr = 32'h1C000008; #1;
    chk("p_c1_data_dok", data_data_ok, 1);
    chk("p_c1_inst_aok", inst_addr_ok, 0);
    for (int i = 2; i <= 5; i++) begin
      tick(); #1;
      chk("p_wait_data_dok", data_data_ok, 0);
      chk("p_wait_inst_aok", inst_addr_ok, 0);
      chk("p_wait_bready", bready, 1);
    end
    tick(); bvalid = 1; awready = 0; wready = 0; #1;
    chk("p_c6_inst_aok", inst_addr_ok, 0);
    chk("p_c6_data_dok", data_data_ok, 0);
    tick(); bvalid = 0; #1;
    chk("p_c7_inst_aok", inst_addr_ok, 1);
    tick(); inst_req = 0; #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Converts the core's two request/ack memory ports (instruction fetch and data load/store) into a single AXI3/AXI4 master.
- Sits directly downstream of the CPU top and replaces the two SRAM ports when the core moves onto the AXI SoC.
- Supports one outstanding transaction in total.
- Fixed-priority arbitration between instruction and data requests.

Parameters:
DATA_FIRST, 1, 1 = data request wins when both are requesting in IDLE; 0 = instruction request wins.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request (read only)
inst_addr  in  32  fetch address, word aligned
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
inst_rdata  out  32  fetched word
data_req  in  1  load/store request
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  4  store byte strobes
data_addr  in  32  load/store address
data_wdata  in  32  store data, already lane-aligned
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  one-cycle pulse: load data valid, or store complete
data_rdata  out  32  loaded word
araddr  out  32  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
awaddr  out  32  AXI write address
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
bvalid  in  1  AXI write response valid
bready  out  1  AXI write response ready

Behaviour:
- Fixed AXI fields are internal constants, not ports:
  - len = 0, size = 3'b010, burst = INCR, id = 0.
  - rresp and bresp are ignored.
- Reset: all outputs go to 0 and the FSM goes to IDLE. Any in-flight transaction is abandoned; the AXI side must be reset together with the core.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - Grant goes to DATA_FIRST's choice among the active reqs.
  - The winner's *_addr_ok is combinational (req && IDLE && grant). The other port's addr_ok stays 0.
  - On grant, latch the address, the source (inst/data) and wr. For stores also latch wdata and wstrb.
  - Next state is RD_ADDR for a read, WR_REQ for a write.
- RD_ADDR:
  - arvalid = 1 and araddr is held stable.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata into the source's rdata register and go to DONE.
- WR_REQ:
  - awvalid and wvalid rise together.
  - Each drops independently once its own ready is seen.
  - Leave only when both handshakes have completed, in the same or different cycles.
  - Next state is WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid, go to DONE.
- DONE:
  - Exactly one cycle.
  - The source's *_data_ok = 1; the rdata register holds its value until the next capture.
  - Return to IDLE. A new request can be granted in the following cycle.
- Only one transaction is in flight at a time. addr_ok is never asserted outside IDLE.
- Minimum latency for both reads and writes is addr_ok at cycle 0 and data_ok at cycle 3, with every ready/valid high immediately.
- If a valid is stalled by its ready being low, address, data and strobes stay stable.
- If a requester drops req before addr_ok, nothing is issued.

Optional Feature:
- Macro: CPU_AXI_BRIDGE_POSTED_WR_EN.
- Defined:
  - Store data_data_ok pulses in the cycle both AW and W are accepted; DONE is skipped for stores.
  - The bridge still waits in WR_RESP for bvalid before returning to IDLE, so ordering is preserved.
- Undefined: stores complete only after B, as described under Behaviour.

Test Plan:
- inst_req, addr 0x1C000000; arready and rvalid high immediately; rdata 0x02800C0C -> inst_addr_ok at c0, arvalid at c1, inst_data_ok with inst_rdata = 0x02800C0C at c3.
- Store to 0x00001004, wdata 0xAABBCCDD, wstrb 4'b0011; awready delayed 3 cycles, wready immediate -> wvalid drops after c1, awvalid held until accepted; then bready; data_data_ok fires one cycle after bvalid.
- inst_req and data_req (load) together with DATA_FIRST = 1 -> only data_addr_ok; inst is granted in the IDLE after DONE. Repeat with DATA_FIRST = 0 -> inst is served first.
- Back-to-back loads while arready is held low 5 cycles -> araddr stable, no second addr_ok until DONE.
- reset asserted while in RD_DATA -> outputs zero immediately (asynchronous); after release, a new fetch completes normally.
- With POSTED_WR_EN, store where AW and W are accepted at c1 and bvalid comes at c6 -> data_data_ok at c1, next addr_ok no earlier than c7.
